rd_burst_sched: RTL and testbench
=================================

# rd_burst_sched

Read-burst scheduler that sits directly upstream of the DDR3 read DMA engine. It walks a frame buffer in DDR3 as a sequence of fixed-length read bursts and issues each burst's start/address/command/length. It throttles requests against the fill level of the downstream read FIFO fed by the DMA's data-valid strobe, and wraps to the frame base address after the last burst of a frame.

## Interface
- ADDR_W, 28, DDR3 app address width
- BASE_ADDR, 28'h0000000, frame start address
- BURST_LEN, 64, app commands per burst (1..255); one FIFO word per command
- FRAME_BURSTS, 16, bursts per frame (≥1)
- FIFO_DEPTH, 512, downstream FIFO capacity in words
- CNT_W, 12, width of FIFO fill-level input
- TIMEOUT_CYCLES, 4096, watchdog limit (only with RD_SCHED_TIMEOUT_EN)

- I_sys_clk  in  1  system/UI clock; all logic on rising edge
- I_Rst  in  1  synchronous, active-high reset
- I_enable  in  1  level; scheduler runs while high
- I_frame_sync  in  1  pulse; restart at BASE_ADDR at next burst boundary
- I_fifo_wr_cnt  in  CNT_W  downstream FIFO fill level, words
- O_rd_start  out  1  burst request to DMA (level, held until accepted)
- O_rd_addr  out  ADDR_W  burst start address
- O_rd_cmd  out  3  constant 3'b001 (read)
- O_rd_burst_len  out  8  constant BURST_LEN
- I_rd_burst_start  in  1  DMA acceptance strobe (one cycle)
- I_rd_burst_end  in  1  DMA completion strobe (one cycle, after last data word)
- O_busy  out  1  high in any state other than IDLE
- O_frame_done  out  1  one-cycle pulse when last burst of a frame completes
- O_err  out  1  sticky watchdog error

## Operation
- States: IDLE, CHECK, REQ, WAIT_END. All outputs registered.
- IDLE: O_rd_addr = BASE_ADDR, burst counter = 0. I_enable high → CHECK.
- CHECK: space = FIFO_DEPTH − I_fifo_wr_cnt, computed at CNT_W+1 bits. If I_fifo_wr_cnt > FIFO_DEPTH, space = 0. space ≥ BURST_LEN → REQ, else stay. I_enable low → IDLE.
- REQ: O_rd_start = 1; address and length stay stable. I_rd_burst_start sampled high → WAIT_END, with O_rd_start low from the next cycle. I_enable is ignored once in REQ.
- WAIT_END: I_rd_burst_end high → burst counter +1, O_rd_addr += BURST_LEN×8 (mod 2^ADDR_W). Next state is CHECK if I_enable, else IDLE.
- Last burst (counter == FRAME_BURSTS−1) at burst_end: counter → 0, O_rd_addr → BASE_ADDR, O_frame_done pulses.
- I_frame_sync: latched into a pending flag in any state. The flag is applied at the next burst_end or in CHECK: counter → 0, addr → BASE_ADDR, no frame_done, flag cleared. If it coincides with the last-burst end, frame_done still pulses and the flag is cleared.
- An in-flight burst is never aborted. Disable during REQ/WAIT_END completes the burst, then goes to IDLE.
- Reset mid-burst returns every register to its reset value. The DMA must be reset on the same edge.

## Timing
- Reset values: O_rd_start 0, O_rd_addr BASE_ADDR, O_busy 0, O_frame_done 0, O_err 0. O_rd_cmd and O_rd_burst_len are constant.
- I_enable sampled high in IDLE → O_rd_start high 2 cycles later (IDLE→CHECK→REQ), given FIFO space.
- I_rd_burst_start high at edge N → O_rd_start low after N. This prevents a double start, because the DMA latches on the same edge.
- I_rd_burst_end at edge N → new address visible after N. Next O_rd_start is high after N+1 if space is available.
- O_frame_done is high exactly the cycle after the final burst_end.

## Configuration
- RD_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT_END and clears on entry.
  - Reaching TIMEOUT_CYCLES without I_rd_burst_end sets O_err (sticky until I_Rst) and forces IDLE.
  - While O_err is set, the scheduler stays in IDLE.
- RD_SCHED_TIMEOUT_EN undefined: no counter, O_err tied 0, WAIT_END waits indefinitely.

## Test plan
Parameters: BASE_ADDR=0x100, BURST_LEN=64, FRAME_BURSTS=4, FIFO_DEPTH=512.
- Basic: enable, fifo_wr_cnt=0, DMA model acks → O_rd_addr sequence 0x100, 0x300, 0x500, 0x700, then 0x100; frame_done pulses once after the 4th burst_end.
- Throttle: fifo_wr_cnt=449 → stays in CHECK with no O_rd_start; drop to 448 → O_rd_start high 1 cycle later.
- Handshake: hold burst_start low 10 cycles in REQ → O_rd_start and addr stable all 10 cycles; burst_start pulse → O_rd_start low next cycle, exactly one burst.
- Frame sync: pulse during burst 2 → after that burst_end, addr = 0x100 and no frame_done; same pulse at the last burst → frame_done=1, addr=0x100.
- Disable/reset: drop enable in WAIT_END → burst completes, then IDLE with busy=0; assert I_Rst mid-REQ → all outputs at reset values next cycle.
- Timeout (macro on, TIMEOUT_CYCLES=100): withhold burst_end → O_err=1 after 100 cycles, IDLE, held until reset.

Source files
------------

// File: rtl/rd_burst_sched.sv
// Read-burst scheduler: walks a frame buffer as fixed-length DDR3 read bursts, throttled by downstream FIFO space.
// Optional watchdog on burst completion is compiled in with RD_SCHED_TIMEOUT_EN.
module rd_burst_sched #(
    parameter int                ADDR_W         = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                BURST_LEN      = 64,
    parameter int                FRAME_BURSTS   = 16,
    parameter int                FIFO_DEPTH     = 512,
    parameter int                CNT_W          = 12,
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  logic              I_sys_clk,
    input  logic              I_Rst,
    input  logic              I_enable,
    input  logic              I_frame_sync,
    input  logic [CNT_W-1:0]  I_fifo_wr_cnt,
    output logic              O_rd_start,
    output logic [ADDR_W-1:0] O_rd_addr,
    output logic [2:0]        O_rd_cmd,
    output logic [7:0]        O_rd_burst_len,
    input  logic              I_rd_burst_start,
    input  logic              I_rd_burst_end,
    output logic              O_busy,
    output logic              O_frame_done,
    output logic              O_err
);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT_END} state_t;

    localparam int                BC_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN * 8);
    localparam logic [CNT_W:0]    DEPTH_X    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    LEN_X      = (CNT_W + 1)'(BURST_LEN);
    localparam logic [BC_W-1:0]   LAST_BURST = BC_W'(FRAME_BURSTS - 1);

    state_t          state;
    logic [BC_W-1:0] burst_cnt;
    logic            sync_pend;
    logic            sync_now;
    logic            err_hold;
    logic [CNT_W:0]  fill;
    logic [CNT_W:0]  space;
    logic            space_ok;

    assign O_rd_cmd       = 3'b001;
    assign O_rd_burst_len = 8'(BURST_LEN);
    assign sync_now       = sync_pend | I_frame_sync;

    // An overfilled FIFO reports more words than its depth; treat that as no space.
    always_comb begin
        fill     = {1'b0, I_fifo_wr_cnt};
        space    = (fill > DEPTH_X) ? '0 : (DEPTH_X - fill);
        space_ok = (space >= LEN_X);
    end

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign err_hold = O_err;
`else
    assign err_hold = 1'b0;
    assign O_err    = 1'b0;
`endif

    always_ff @(posedge I_sys_clk) begin
        if (I_Rst) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            sync_pend    <= 1'b0;
            O_rd_start   <= 1'b0;
            O_rd_addr    <= BASE_ADDR;
            O_busy       <= 1'b0;
            O_frame_done <= 1'b0;
`ifdef RD_SCHED_TIMEOUT_EN
            tmo_cnt      <= '0;
            O_err        <= 1'b0;
`endif
        end else begin
            O_frame_done <= 1'b0;
            if (I_frame_sync) sync_pend <= 1'b1;
            case (state)
                IDLE: begin
                    O_rd_addr <= BASE_ADDR;
                    burst_cnt <= '0;
                    if (I_enable && !err_hold) begin
                        state  <= CHECK;
                        O_busy <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!I_enable) begin
                        state     <= IDLE;
                        O_busy    <= 1'b0;
                        O_rd_addr <= BASE_ADDR;
                        burst_cnt <= '0;
                    end else begin
                        if (sync_now) begin
                            O_rd_addr <= BASE_ADDR;
                            burst_cnt <= '0;
                            sync_pend <= 1'b0;
                        end
                        if (space_ok) begin
                            state      <= REQ;
                            O_rd_start <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // The DMA latches on this same edge, so the request must drop now.
                    if (I_rd_burst_start) begin
                        state      <= WAIT_END;
                        O_rd_start <= 1'b0;
`ifdef RD_SCHED_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                WAIT_END: begin
                    if (I_rd_burst_end) begin
                        if (burst_cnt == LAST_BURST) begin
                            burst_cnt    <= '0;
                            O_rd_addr    <= BASE_ADDR;
                            O_frame_done <= 1'b1;
                            sync_pend    <= 1'b0;
                        end else if (sync_now) begin
                            burst_cnt <= '0;
                            O_rd_addr <= BASE_ADDR;
                            sync_pend <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            O_rd_addr <= O_rd_addr + ADDR_STEP;
                        end
                        if (I_enable) begin
                            state <= CHECK;
                        end else begin
                            state     <= IDLE;
                            O_busy    <= 1'b0;
                            O_rd_addr <= BASE_ADDR;
                            burst_cnt <= '0;
                        end
                    end
`ifdef RD_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        O_err     <= 1'b1;
                        state     <= IDLE;
                        O_busy    <= 1'b0;
                        O_rd_addr <= BASE_ADDR;
                        burst_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_burst_sched.sv
// Bench for rd_burst_sched: directed scenarios with literal expectations plus randomized traffic against a reference model.
module tb_rd_burst_sched;

    localparam int BASE  = 'h100;
    localparam int BLEN  = 64;
    localparam int FB    = 4;
    localparam int DEPTH = 512;
    localparam int TMO   = 100;
    localparam int STEP  = BLEN * 8;

    logic        clk = 1'b0;
    logic        rst, en, sync, bs, be;
    logic [11:0] wr_cnt;
    logic        rd_start, busy, frame_done, err;
    logic [27:0] rd_addr;
    logic [2:0]  rd_cmd;
    logic [7:0]  rd_len;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit dma_auto = 0;
    int dma_busy = 0;
    int dma_cnt = 0;

    always #5 clk = ~clk;

    rd_burst_sched #(
        .ADDR_W(28), .BASE_ADDR(28'h100), .BURST_LEN(BLEN), .FRAME_BURSTS(FB),
        .FIFO_DEPTH(DEPTH), .CNT_W(12), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .I_sys_clk(clk), .I_Rst(rst), .I_enable(en), .I_frame_sync(sync),
        .I_fifo_wr_cnt(wr_cnt), .O_rd_start(rd_start), .O_rd_addr(rd_addr),
        .O_rd_cmd(rd_cmd), .O_rd_burst_len(rd_len), .I_rd_burst_start(bs),
        .I_rd_burst_end(be), .O_busy(busy), .O_frame_done(frame_done), .O_err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which burst of the frame is next and what the scheduler is doing.
    localparam int P_OFF = 0, P_GATE = 1, P_ASK = 2, P_XFER = 3;
    int m_phase = P_OFF;
    int m_idx = 0;
    bit m_pend = 0;
    bit m_done = 0;
    bit m_err = 0;
    int m_wait = 0;

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_phase = P_OFF; m_idx = 0; m_pend = 0; m_err = 0; m_wait = 0;
        end else begin
            if (sync) m_pend = 1;
            if (m_phase == P_OFF) begin
                m_idx = 0;
                if (en && !m_err) m_phase = P_GATE;
            end else if (m_phase == P_GATE) begin
                if (!en) begin
                    m_phase = P_OFF; m_idx = 0;
                end else begin
                    if (m_pend) begin m_idx = 0; m_pend = 0; end
                    if (DEPTH - int'(wr_cnt) >= BLEN) m_phase = P_ASK;
                end
            end else if (m_phase == P_ASK) begin
                if (bs) begin m_phase = P_XFER; m_wait = 0; end
            end else begin
                if (be) begin
                    if (m_idx == FB - 1) begin m_idx = 0; m_done = 1; m_pend = 0; end
                    else if (m_pend) begin m_idx = 0; m_pend = 0; end
                    else m_idx = m_idx + 1;
                    if (en) m_phase = P_GATE;
                    else begin m_phase = P_OFF; m_idx = 0; end
                end else begin
`ifdef RD_SCHED_TIMEOUT_EN
                    m_wait = m_wait + 1;
                    if (m_wait == TMO) begin m_err = 1; m_phase = P_OFF; m_idx = 0; end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("start", 32'(rd_start), 32'(m_phase == P_ASK));
            chk("addr", 32'(rd_addr), 32'(28'(BASE + m_idx * STEP)));
            chk("busy", 32'(busy), 32'(m_phase != P_OFF));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("consts", {21'd0, rd_cmd, rd_len}, {21'd0, 3'b001, 8'd64});
        end
    end

    task automatic dma_step();
        bs = 0; be = 0;
        if (dma_busy != 0) begin
            if (dma_cnt == 0) begin be = 1; dma_busy = 0; dma_cnt = int'($urandom_range(0, 3)); end
            else dma_cnt--;
        end else if (rd_start) begin
            if (dma_cnt == 0) begin bs = 1; dma_busy = 1; dma_cnt = int'($urandom_range(0, 12)); end
            else dma_cnt--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (dma_auto) dma_step();
    endtask

    task automatic do_reset();
        rst = 1; en = 0; sync = 0; bs = 0; be = 0; wr_cnt = 0;
        dma_auto = 0; dma_busy = 0; dma_cnt = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 50 && !rd_start; i++) tick();
        if (!rd_start) chk(name, 32'(rd_start), 32'd1);
    endtask

    task automatic burst(input bit sync_mid, output logic [27:0] a);
        wait_start("burst_wait");
        a = rd_addr;
        bs = 1; tick(); bs = 0;
        if (sync_mid) begin sync = 1; tick(); sync = 0; end
        tick(); tick();
        be = 1; tick(); be = 0;
    endtask

    logic [27:0] exp_seq [5];
    logic [27:0] got_q [$];
    logic [27:0] a;
    int ndone;
    bit prev, seen, stable;

    initial begin
        exp_seq = '{28'h100, 28'h300, 28'h500, 28'h700, 28'h100};
        rst = 1; en = 0; sync = 0; bs = 0; be = 0; wr_cnt = 0;
        tick();
        chk_en = 1;
        tick();
        chk("reset_outs", {27'd0, rd_start, busy, frame_done, err, 1'b0}, 32'd0);
        chk("reset_addr", 32'(rd_addr), 32'h100);

        // Basic frame walk
        do_reset();
        dma_auto = 1; en = 1;
        tick();
        chk("en_to_check", {30'd0, rd_start, busy}, 32'b01);
        tick();
        chk("en_to_req", 32'(rd_start), 32'd1);
        prev = 0; ndone = 0;
        for (int i = 0; i < 600 && got_q.size() < 5; i++) begin
            if (rd_start && !prev) got_q.push_back(rd_addr);
            if (frame_done) ndone++;
            prev = rd_start;
            if (got_q.size() < 5) tick();
        end
        chk("basic_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("basic_addr", 32'(got_q[i]), 32'(exp_seq[i]));
        chk("basic_frame_done", 32'(ndone), 32'd1);

        // Throttle on FIFO fill level
        do_reset();
        wr_cnt = 449; en = 1; seen = 0;
        for (int i = 0; i < 12; i++) begin tick(); seen |= rd_start; end
        chk("throttle_hold", 32'(seen), 32'd0);
        chk("throttle_busy", 32'(busy), 32'd1);
        wr_cnt = 448;
        tick();
        chk("throttle_release", 32'(rd_start), 32'd1);

        // Handshake: request held until accepted
        do_reset();
        en = 1; tick(); tick();
        chk("hs_req", 32'(rd_start), 32'd1);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rd_start || rd_addr != 28'h100) stable = 0;
        end
        chk("hs_stable", 32'(stable), 32'd1);
        bs = 1; tick(); bs = 0;
        chk("hs_drop", 32'(rd_start), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); seen |= rd_start; end
        chk("hs_single", 32'(seen), 32'd0);
        be = 1; tick(); be = 0;
        chk("hs_next_addr", 32'(rd_addr), 32'h300);
        chk("hs_gap", 32'(rd_start), 32'd0);
        tick();
        chk("hs_restart", 32'(rd_start), 32'd1);

        // Frame sync mid-frame and at the last burst
        do_reset();
        en = 1;
        burst(0, a); chk("fs_a0", 32'(a), 32'h100);
        burst(1, a); chk("fs_a1", 32'(a), 32'h300);
        chk("fs_mid_addr", 32'(rd_addr), 32'h100);
        chk("fs_mid_done", 32'(frame_done), 32'd0);
        burst(0, a); burst(0, a); burst(0, a);
        chk("fs_a2", 32'(a), 32'h500);
        burst(1, a); chk("fs_a3", 32'(a), 32'h700);
        chk("fs_last_done", 32'(frame_done), 32'd1);
        chk("fs_last_addr", 32'(rd_addr), 32'h100);

        // Disable during a burst completes it, then idles
        do_reset();
        en = 1;
        wait_start("dis_wait");
        bs = 1; tick(); bs = 0;
        en = 0; tick(); tick();
        chk("dis_busy_wait", 32'(busy), 32'd1);
        be = 1; tick(); be = 0;
        chk("dis_idle", {30'd0, busy, rd_start}, 32'd0);
        chk("dis_addr", 32'(rd_addr), 32'h100);

        // Reset while requesting
        do_reset();
        en = 1;
        wait_start("rst_wait");
        rst = 1; tick(); rst = 0; en = 0;
        chk("rst_mid_req", {27'd0, rd_start, busy, frame_done, err, 1'b0}, 32'd0);
        chk("rst_mid_addr", 32'(rd_addr), 32'h100);

`ifdef RD_SCHED_TIMEOUT_EN
        do_reset();
        en = 1;
        wait_start("tmo_wait");
        bs = 1; tick(); bs = 0;
        for (int i = 0; i < 99; i++) tick();
        chk("tmo_before", 32'(err), 32'd0);
        tick();
        chk("tmo_err", {30'd0, err, busy}, 32'b10);
        for (int i = 0; i < 10; i++) tick();
        chk("tmo_hold", {29'd0, err, busy, rd_start}, 32'b100);
        rst = 1; tick(); rst = 0;
        chk("tmo_clear", 32'(err), 32'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        dma_auto = 1; en = 1;
        for (int i = 0; i < 4000; i++) begin
            sync = 0;
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) sync = 1;
            if ($urandom_range(0, 7) == 0) wr_cnt = 12'($urandom_range(0, 600));
            if ($urandom_range(0, 799) == 0) begin
                rst = 1; dma_busy = 0; dma_cnt = 0; bs = 0; be = 0;
                tick();
                rst = 0;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
